// File: rtl/cdec_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cdec_mon_pkg
// Purpose  : Shared types and constants for the register monitor.
//            - mon_state_t : scan sequencer state encoding
//            - c_seg_glyph : active-low {g,f,e,d,c,b,a} glyphs for 0-F
//            - c_seg_blank : all segments off
// Revision : 1.0 - initial release
// ============================================================================
package cdec_mon_pkg;

    typedef enum logic [1:0] {
        ST_SET     = 2'd0,
        ST_WAIT    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DWELL   = 2'd3
    } mon_state_t;

    // Entry [n] is the glyph for hex digit n (entry 15 listed first).
    localparam logic [15:0][6:0] c_seg_glyph = {
        7'h0E,  // F
        7'h06,  // E
        7'h21,  // d
        7'h46,  // C
        7'h03,  // b
        7'h08,  // A
        7'h10,  // 9
        7'h00,  // 8
        7'h78,  // 7
        7'h02,  // 6
        7'h12,  // 5
        7'h19,  // 4
        7'h30,  // 3
        7'h24,  // 2
        7'h79,  // 1
        7'h40   // 0
    };

    localparam logic [6:0] c_seg_blank = 7'h7F;

endpackage : cdec_mon_pkg
`default_nettype wire

// File: rtl/reg_monitor_hex7seg.sv
`default_nettype none
// ============================================================================
// Module   : hex7seg
// Purpose  : Combinational nibble to active-low 7-segment decoder.
// Ports    : nibble [3:0] in  - hex digit to show
//            blank        in  - 1 forces all segments off
//            seg    [6:0] out - active-low {g,f,e,d,c,b,a}
// Revision : 1.0 - initial release
// ============================================================================
module hex7seg
    import cdec_mon_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    assign seg = blank ? c_seg_blank : c_seg_glyph[nibble];

endmodule : hex7seg
`default_nettype wire

// File: rtl/reg_monitor.sv
`default_nettype none
// ============================================================================
// Module   : reg_monitor
// Purpose  : Scans CPU-shell registers (auto range or a manual address),
//            captures address/data samples and shows them on four
//            seven-segment digits.
// Ports    : clock, reset     in  - clock, synchronous active-high reset
//            auto_en          in  - 1 auto-scan, 0 manual address
//            sel_addr [7:0]   in  - manual register address
//            hold             in  - freezes the dwell phase
//            resad    [7:0]   out - registered read address to the shell
//            resdt    [7:0]   in  - shell read data (combinational of resad)
//            cur_addr [7:0]   out - last captured address
//            cur_data [7:0]   out - last captured data
//            valid            out - at least one capture since reset
//            hex3..hex0 [6:0] out - addr hi/lo, data hi/lo (active low)
// Revision : 1.0 - initial release
// ============================================================================
module reg_monitor
    import cdec_mon_pkg::*;
#(
    parameter int         SCAN_DIV  = 12500000,
    parameter logic [7:0] ADDR_BASE = 8'h00,
    parameter logic [7:0] ADDR_LAST = 8'h0F
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       auto_en,
    input  logic [7:0] sel_addr,
    input  logic       hold,
    output logic [7:0] resad,
    input  logic [7:0] resdt,
    output logic [7:0] cur_addr,
    output logic [7:0] cur_data,
    output logic       valid,
    output logic [6:0] hex3,
    output logic [6:0] hex2,
    output logic [6:0] hex1,
    output logic [6:0] hex0
);

    // A one-cycle dwell still needs a 1-bit counter.
    localparam int              CNT_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(SCAN_DIV - 1);
    localparam logic [7:0]       c_span     = ADDR_LAST - ADDR_BASE;

    mon_state_t       r_state;
    mon_state_t       w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_resad;
    logic [7:0]       r_cur_addr;
    logic [7:0]       r_cur_data;
    logic             r_valid;
    logic [7:0]       w_offset;
    logic [7:0]       w_next_addr;
    logic             w_dwell_done;

    // ------------------------------------------------------------------
    // Next scan address. The offset from ADDR_BASE wraps modulo 256, so an
    // address below the base shows up as a large offset and, like anything
    // at or above ADDR_LAST, restarts the scan at ADDR_BASE.
    // ------------------------------------------------------------------
    assign w_offset = r_resad - ADDR_BASE;

    always_comb begin
        w_next_addr = sel_addr;
        if (auto_en) begin
            if (w_offset >= c_span) begin
                w_next_addr = ADDR_BASE;
            end else begin
                w_next_addr = r_resad + 8'd1;
            end
        end
    end

    assign w_dwell_done = (!hold) && (r_cnt == c_cnt_last);

    // ------------------------------------------------------------------
    // Sequencer: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            // Reset enters WAIT so ADDR_BASE (loaded into resad) is sampled
            // first, independent of auto_en.
            r_state <= ST_WAIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_SET:     w_state_next = ST_WAIT;
            ST_WAIT:    w_state_next = ST_CAPTURE;
            ST_CAPTURE: w_state_next = ST_DWELL;
            ST_DWELL:   if (w_dwell_done) w_state_next = ST_SET;
            default:    w_state_next = ST_WAIT;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: read address, dwell counter and captured sample
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_resad    <= ADDR_BASE;
            r_cnt      <= '0;
            r_cur_addr <= 8'h00;
            r_cur_data <= 8'h00;
            r_valid    <= 1'b0;
        end else begin
            case (r_state)
                ST_SET: begin
                    r_resad <= w_next_addr;
                end
                ST_CAPTURE: begin
                    r_cur_addr <= r_resad;
                    r_cur_data <= resdt;
                    r_valid    <= 1'b1;
                    r_cnt      <= '0;
                end
                ST_DWELL: begin
                    // Counter holds at its last value on exit; CAPTURE
                    // clears it before the next dwell.
                    if (!hold && (r_cnt != c_cnt_last)) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign resad    = r_resad;
    assign cur_addr = r_cur_addr;
    assign cur_data = r_cur_data;
    assign valid    = r_valid;

    // ------------------------------------------------------------------
    // Display: digit 3..0 = addr hi, addr lo, data hi, data lo
    // ------------------------------------------------------------------
    logic [3:0][3:0] w_nib;
    logic [3:0][6:0] w_seg;

    assign w_nib = {r_cur_addr, r_cur_data};

    for (genvar gi = 0; gi < 4; gi++) begin : g_hex
        hex7seg u_hex7seg (
            .nibble (w_nib[gi]),
            .blank  (!r_valid),
            .seg    (w_seg[gi])
        );
    end

    assign hex3 = w_seg[3];
    assign hex2 = w_seg[2];
    assign hex1 = w_seg[1];
    assign hex0 = w_seg[0];

endmodule : reg_monitor
`default_nettype wire

// File: tb/tb_reg_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_monitor
// Purpose  : Self-checking bench for reg_monitor. A SCAN_DIV=4 instance
//            (range 08..0A) and a SCAN_DIV=1 instance share the stimulus;
//            the CPU shell is modelled as resdt = resad ^ 8'hA5.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_monitor;

    localparam int         DIV  = 4;
    localparam logic [7:0] BASE = 8'h08;
    localparam logic [7:0] LAST = 8'h0A;

    logic       clock = 1'b0;
    logic       reset;
    logic       auto_en;
    logic [7:0] sel_addr;
    logic       hold;

    logic [7:0] resad_a, resdt_a, cur_addr_a, cur_data_a;
    logic       valid_a;
    logic [6:0] hex3_a, hex2_a, hex1_a, hex0_a;
    logic [7:0] resad_b, resdt_b, cur_addr_b, cur_data_b;
    logic       valid_b;
    logic [6:0] hex3_b, hex2_b, hex1_b, hex0_b;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    assign resdt_a = resad_a ^ 8'hA5;
    assign resdt_b = resad_b ^ 8'hA5;

    reg_monitor #(.SCAN_DIV(DIV), .ADDR_BASE(BASE), .ADDR_LAST(LAST)) u_dut_a (
        .clock(clock), .reset(reset), .auto_en(auto_en), .sel_addr(sel_addr),
        .hold(hold), .resad(resad_a), .resdt(resdt_a), .cur_addr(cur_addr_a),
        .cur_data(cur_data_a), .valid(valid_a),
        .hex3(hex3_a), .hex2(hex2_a), .hex1(hex1_a), .hex0(hex0_a)
    );

    reg_monitor #(.SCAN_DIV(1), .ADDR_BASE(BASE), .ADDR_LAST(LAST)) u_dut_b (
        .clock(clock), .reset(reset), .auto_en(auto_en), .sel_addr(sel_addr),
        .hold(hold), .resad(resad_b), .resdt(resdt_b), .cur_addr(cur_addr_b),
        .cur_data(cur_data_b), .valid(valid_b),
        .hex3(hex3_b), .hex2(hex2_b), .hex1(hex1_b), .hex0(hex0_b)
    );

    // ------------------------------------------------------------------
    // Reference model: position p within one revisit period of div+3
    // cycles (0..div-1 dwell, div = address select, div+1 = settle,
    // div+2 = capture).
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [15:0] p;
        logic [7:0]  resad;
        logic [7:0]  addr;
        logic [7:0]  data;
        logic        valid;
    } mstate_t;

    function automatic logic [7:0] next_auto(input logic [7:0] a);
        int span;
        span = int'(LAST) - int'(BASE) + 1;
        if (a >= BASE && a <= LAST) return 8'(int'(BASE) + ((int'(a) - int'(BASE) + 1) % span));
        return BASE;
    endfunction

    function automatic mstate_t mstep(input mstate_t s, input int div, input logic rst,
                                      input logic ae, input logic [7:0] sa, input logic hd);
        mstate_t n;
        n = s;
        if (rst) begin
            n.p = 16'(div + 1); n.resad = BASE; n.addr = 8'h00; n.data = 8'h00; n.valid = 1'b0;
        end else if (int'(s.p) < div) begin
            if (!hd) n.p = s.p + 16'd1;
        end else if (int'(s.p) == div) begin
            n.resad = ae ? next_auto(s.resad) : sa;
            n.p     = s.p + 16'd1;
        end else if (int'(s.p) == div + 1) begin
            n.p = s.p + 16'd1;
        end else begin
            n.addr = s.resad; n.data = s.resad ^ 8'hA5; n.valid = 1'b1; n.p = 16'd0;
        end
        return n;
    endfunction

    mstate_t m_a = '0;
    mstate_t m_b = '0;

    always @(posedge clock) begin
        m_a <= mstep(m_a, DIV, reset, auto_en, sel_addr, hold);
        m_b <= mstep(m_b, 1,   reset, auto_en, sel_addr, hold);
    end

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
            4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
            4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
            4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
        endcase
    endfunction

    function automatic logic [27:0] hex_exp(input logic [7:0] a, input logic [7:0] d, input logic v);
        if (!v) return {4{7'h7F}};
        return {glyph(a[7:4]), glyph(a[3:0]), glyph(d[7:4]), glyph(d[3:0])};
    endfunction

    // ------------------------------------------------------------------
    // Checks
    // ------------------------------------------------------------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check_model(input string name);
        logic [52:0] got, exp;
        got = {resad_a, cur_addr_a, cur_data_a, valid_a, hex3_a, hex2_a, hex1_a, hex0_a};
        exp = {m_a.resad, m_a.addr, m_a.data, m_a.valid, hex_exp(m_a.addr, m_a.data, m_a.valid)};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s div4 got=%h expected=%h", name, got, exp);
        end
        got = {resad_b, cur_addr_b, cur_data_b, valid_b, hex3_b, hex2_b, hex1_b, hex0_b};
        exp = {m_b.resad, m_b.addr, m_b.data, m_b.valid, hex_exp(m_b.addr, m_b.data, m_b.valid)};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s div1 got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic check_out(input string name, input logic [7:0] ea, input logic [7:0] ed,
                             input logic ev);
        logic [52:0] got, exp;
        got = {cur_addr_a, cur_data_a, valid_a, hex3_a, hex2_a, hex1_a, hex0_a, 8'h00};
        exp = {ea, ed, ev, hex_exp(ea, ed, ev), 8'h00};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got[52:8], exp[52:8]);
        end
    endtask

    task automatic check_resad(input string name, input logic [7:0] e);
        checks++;
        if (resad_a !== e) begin
            errors++;
            $display("FAIL %s resad got=%h expected=%h", name, resad_a, e);
        end
    endtask

    typedef struct {
        logic       rst;
        logic       ae;
        logic [7:0] sel;
        logic       hd;
        int         cyc;
        logic [7:0] ea;
        logic [7:0] ed;
        logic       ev;
    } vec_t;

    vec_t vecs [10];

    initial begin
        reset    = 1'b1;
        auto_en  = 1'b0;
        sel_addr = 8'h00;
        hold     = 1'b0;

        vecs[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 2, 8'h00, 8'h00, 1'b0}; // reset state
        vecs[1] = '{1'b0, 1'b1, 8'h00, 1'b0, 1, 8'h00, 8'h00, 1'b0}; // still settling
        vecs[2] = '{1'b0, 1'b1, 8'h00, 1'b0, 1, 8'h08, 8'hAD, 1'b1}; // first capture
        vecs[3] = '{1'b0, 1'b1, 8'h00, 1'b0, 6, 8'h08, 8'hAD, 1'b1}; // one short of period
        vecs[4] = '{1'b0, 1'b1, 8'h00, 1'b0, 1, 8'h09, 8'hAC, 1'b1};
        vecs[5] = '{1'b0, 1'b1, 8'h00, 1'b0, 7, 8'h0A, 8'hAF, 1'b1};
        vecs[6] = '{1'b0, 1'b1, 8'h00, 1'b0, 7, 8'h08, 8'hAD, 1'b1}; // wrap
        vecs[7] = '{1'b0, 1'b0, 8'h20, 1'b0, 2, 8'h08, 8'hAD, 1'b1}; // manual mid-dwell
        vecs[8] = '{1'b0, 1'b0, 8'h20, 1'b0, 5, 8'h20, 8'h85, 1'b1};
        vecs[9] = '{1'b0, 1'b0, 8'h33, 1'b0, 7, 8'h33, 8'h96, 1'b1};

        for (int i = 0; i < 10; i++) begin
            reset    = vecs[i].rst;
            auto_en  = vecs[i].ae;
            sel_addr = vecs[i].sel;
            hold     = vecs[i].hd;
            step(vecs[i].cyc);
            check_out($sformatf("vec%0d", i), vecs[i].ea, vecs[i].ed, vecs[i].ev);
            check_model($sformatf("vec%0d_model", i));
        end

        // Hold for 20 cycles mid-dwell; sel change must wait for next select.
        step(2);
        hold     = 1'b1;
        sel_addr = 8'h44;
        for (int i = 0; i < 20; i++) begin
            step(1);
            check_out($sformatf("hold_c%0d", i), 8'h33, 8'h96, 1'b1);
        end
        hold = 1'b0;
        step(4);
        check_out("hold_resume_pre", 8'h33, 8'h96, 1'b1);
        step(1);
        check_out("hold_resume_cap", 8'h44, 8'hE1, 1'b1);
        check_model("hold_model");

        // Out-of-range address under auto scan restarts at the base.
        auto_en = 1'b1;
        step(7);
        check_out("oor_to_base", 8'h08, 8'hAD, 1'b1);
        step(5);
        check_resad("set_09", 8'h09);
        reset = 1'b1;
        step(1);
        check_out("rst_in_wait", 8'h00, 8'h00, 1'b0);
        check_resad("rst_in_wait", 8'h08);
        reset = 1'b0;
        step(2);
        check_out("after_rst_cap", 8'h08, 8'hAD, 1'b1);
        check_model("after_rst_model");

        // Randomized run against the model.
        for (int i = 0; i < 400; i++) begin
            reset    = ($urandom_range(0, 39) == 0);
            auto_en  = ($urandom_range(0, 3) != 0);
            sel_addr = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(6, 12)) : 8'($urandom);
            hold     = ($urandom_range(0, 3) == 0);
            step(1);
            check_model($sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_reg_monitor
`default_nettype wire
